// File: rtl/rv_pkg.sv
// Shared rv32 peripheral definitions: bus word types, GPIO window base and
// register offsets within the 32-byte GPIO window.
package rv_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    localparam u32_t GPIO_BASE = 32'hffff_0060;

    localparam logic [4:0] GPIO_OUT  = 5'h00;
    localparam logic [4:0] GPIO_SET  = 5'h04;
    localparam logic [4:0] GPIO_CLR  = 5'h08;
    localparam logic [4:0] GPIO_TGL  = 5'h0C;
    localparam logic [4:0] GPIO_IN   = 5'h10;
    localparam logic [4:0] GPIO_REN  = 5'h14;
    localparam logic [4:0] GPIO_FEN  = 5'h18;
    localparam logic [4:0] GPIO_STAT = 5'h1C;

    localparam int DEB_CNT_W = 8;

endpackage

// File: rtl/rv_gpio_deb.sv
// Single-bit pin synchroniser and debouncer. q is the NEXT debounced level so
// the parent can register it and see the change in the same cycle for edges.
module rv_gpio_deb
    import rv_pkg::*;
#(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic xreset,
    input  logic d,
    output logic q
);

    logic sync1_reg;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            sync1_reg <= 1'b0;
        end else begin
            sync1_reg <= d;
        end
    end

    generate
        if (DEB_LEN == 0) begin : g_bypass
            // The parent's level register acts as the second sync stage.
            assign q = sync1_reg;
        end else begin : g_deb
            localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEB_LEN - 1);

            logic                 sync2_reg;
            logic                 level_reg;
            logic                 level_next;
            logic [DEB_CNT_W-1:0] cnt_reg;
            logic [DEB_CNT_W-1:0] cnt_next;

            always_comb begin
                level_next = level_reg;
                cnt_next   = '0;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        level_next = sync2_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge xreset) begin
                if (!xreset) begin
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync2_reg <= sync1_reg;
                    level_reg <= level_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign q = level_next;
        end
    endgenerate

endmodule

// File: rtl/rv_gpio.sv
// Memory-mapped NBITS-wide GPIO: output register with set/clear/toggle
// aliases, debounced inputs, per-bit edge capture and an OR-reduced interrupt.
module rv_gpio
    import rv_pkg::*;
#(
    parameter int               NBITS    = 8,
    parameter logic [NBITS-1:0] OUT_INIT = '0,
    parameter int               DEB_LEN  = 4
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic [4:0]       adr,
    input  logic             cs,
    input  logic             rdy,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [31:0]      dw,
    output logic [31:0]      dr,
    input  logic [NBITS-1:0] gpio_in,
    output logic [NBITS-1:0] gpio_out,
    output logic             irq
);

    logic             wr;
    logic             rd;
    logic [4:0]       word_adr;
    u32_t             wmask;
    u32_t             wdata;
    logic [NBITS-1:0] wbits;
    logic [NBITS-1:0] mbits;

    logic [NBITS-1:0] out_reg,  out_next;
    logic [NBITS-1:0] ren_reg,  ren_next;
    logic [NBITS-1:0] fen_reg,  fen_next;
    logic [NBITS-1:0] stat_reg, stat_next;
    logic [NBITS-1:0] in_reg,   in_next;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] fall;
    logic [NBITS-1:0] w1c;
    u32_t             rdata;
    u32_t             dr_reg;
    logic             irq_reg;
    logic             unused_bits;

    assign wr       = cs & rdy & (we != 4'b0000);
    assign rd       = cs & rdy & re;
    assign word_adr = {adr[4:2], 2'b00};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{we[gi]}};
        end
    endgenerate

    assign wdata = dw & wmask;
    assign wbits = wdata[NBITS-1:0];
    assign mbits = wmask[NBITS-1:0];

    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_pin
            rv_gpio_deb #(
                .DEB_LEN (DEB_LEN)
            ) u_deb (
                .clk    (clk),
                .xreset (xreset),
                .d      (gpio_in[gi]),
                .q      (in_next[gi])
            );
        end
    endgenerate

    assign rise = in_next & ~in_reg;
    assign fall = ~in_next & in_reg;

    // Register writes; bits outside the enabled byte lanes are preserved.
    always_comb begin
        out_next = out_reg;
        ren_next = ren_reg;
        fen_next = fen_reg;
        w1c      = '0;
        if (wr) begin
            case (word_adr)
                GPIO_OUT:  out_next = (out_reg & ~mbits) | wbits;
                GPIO_SET:  out_next = out_reg | wbits;
                GPIO_CLR:  out_next = out_reg & ~wbits;
                GPIO_TGL:  out_next = out_reg ^ wbits;
                GPIO_REN:  ren_next = (ren_reg & ~mbits) | wbits;
                GPIO_FEN:  fen_next = (fen_reg & ~mbits) | wbits;
                GPIO_STAT: w1c      = wbits;
                default:   ;
            endcase
        end
    end

    // A new edge in the same cycle as its W1C keeps the bit set.
    assign stat_next = (stat_reg & ~w1c) | (rise & ren_reg) | (fall & fen_reg);

    always_comb begin
        rdata = '0;
        case (word_adr)
            GPIO_OUT:  rdata[NBITS-1:0] = out_reg;
            GPIO_IN:   rdata[NBITS-1:0] = in_reg;
            GPIO_REN:  rdata[NBITS-1:0] = ren_reg;
            GPIO_FEN:  rdata[NBITS-1:0] = fen_reg;
            GPIO_STAT: rdata[NBITS-1:0] = stat_reg;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            out_reg  <= OUT_INIT;
            ren_reg  <= '0;
            fen_reg  <= '0;
            stat_reg <= '0;
            in_reg   <= '0;
            dr_reg   <= '0;
            irq_reg  <= 1'b0;
        end else begin
            out_reg  <= out_next;
            ren_reg  <= ren_next;
            fen_reg  <= fen_next;
            stat_reg <= stat_next;
            in_reg   <= in_next;
            dr_reg   <= rd ? rdata : '0;
            irq_reg  <= |stat_reg;
        end
    end

    assign dr       = dr_reg;
    assign gpio_out = out_reg;
    assign irq      = irq_reg;

    assign unused_bits = ^{adr[1:0], wdata, wmask};

endmodule
